// File: rtl/imem_ctrl_pkg.sv
// Shared constants, packet layout, FSM state codes and the packet builder
// for the ifmap memory sequencer.
package imem_ctrl_pkg;

    localparam int IFMAP_DIM   = 25;
    localparam int FILTER_DIM  = 5;
    localparam int NUM_TS      = 2;
    localparam int ADDR_W      = 12;
    localparam int PKT_W       = 33;
    localparam int PE_BASE     = 5;
    localparam int SELF_ADDR   = 11;
    localparam int TSDONE_DEST = 12;

    // Router packet field positions: dest[32:29], opcode[28:25], data[24:0]
    localparam int DEST_MSB   = 32;
    localparam int DEST_LSB   = 29;
    localparam int OPC_MSB    = 28;
    localparam int OPC_LSB    = 25;
    localparam int PKT_DATA_W = 25;

    localparam logic [3:0] OPC_WDONE   = 4'd0;
    localparam logic [3:0] OPC_IFROW   = 4'd1;
    localparam logic [3:0] OPC_ROWDONE = 4'd2;
    localparam logic [3:0] OPC_TSDONE  = 4'd10;

    // Sequencer state codes
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_WAIT_W  = 3'd2;
    localparam logic [2:0] ST_RD_ROW  = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_RD = 3'd5;
    localparam logic [2:0] ST_TS_END  = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    typedef struct packed {
        logic [3:0]            dest;
        logic [3:0]            opcode;
        logic [PKT_DATA_W-1:0] data;
    } pkt_t;

    function automatic pkt_t make_pkt(input logic [3:0] dest,
                                      input logic [3:0] opcode,
                                      input logic [PKT_DATA_W-1:0] data);
        pkt_t p;
        p.dest   = dest;
        p.opcode = opcode;
        p.data   = data;
        return p;
    endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Bundle of the load stream, ifmap RAM port and router in/out ports.
// slave = the sequencer side, master = host / RAM / router side.
interface imem_ctrl_if;
    import imem_ctrl_pkg::*;

    logic                 load_start;
    logic                 load_valid;
    logic                 load_ready;
    logic [1:0]           load_ts;
    logic [ADDR_W-1:0]    load_addr;
    logic                 load_data;
    logic                 load_done;

    logic                 mem_we;
    logic                 mem_wts;
    logic [ADDR_W-1:0]    mem_waddr;
    logic                 mem_wdata;
    logic                 mem_re;
    logic                 mem_rts;
    logic [4:0]           mem_rrow;
    logic [IFMAP_DIM-1:0] mem_rdata;

    logic                 rin_valid;
    logic                 rin_ready;
    logic [PKT_W-1:0]     rin_pkt;

    logic                 rout_valid;
    logic                 rout_ready;
    logic [PKT_W-1:0]     rout_pkt;

    modport slave (
        input  load_start, load_valid, load_ts, load_addr, load_data, load_done,
        output load_ready,
        output mem_we, mem_wts, mem_waddr, mem_wdata, mem_re, mem_rts, mem_rrow,
        input  mem_rdata,
        input  rin_valid, rin_pkt,
        output rin_ready,
        output rout_valid, rout_pkt,
        input  rout_ready
    );

    modport master (
        output load_start, load_valid, load_ts, load_addr, load_data, load_done,
        input  load_ready,
        input  mem_we, mem_wts, mem_waddr, mem_wdata, mem_re, mem_rts, mem_rrow,
        output mem_rdata,
        output rin_valid, rin_pkt,
        input  rin_ready,
        input  rout_valid, rout_pkt,
        output rout_ready
    );

endinterface

// File: rtl/imem_ctrl_pkt_out_reg.sv
// Single-entry outbound packet register: once loaded, valid and the packet
// stay put until the router accepts it.
module imem_ctrl_pkt_out_reg
    import imem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  pkt_t pkt_i,
    input  logic ready_i,
    output logic valid_o,
    output pkt_t pkt_o,
    output logic fire_o
);

    logic valid_q;
    pkt_t pkt_q;

    // Valid flag: set on load, cleared by the handshake or reset
    always_ff @(posedge clk) begin
        if (!rst_n)                  valid_q <= 1'b0;
        else if (load_i)             valid_q <= 1'b1;
        else if (valid_q && ready_i) valid_q <= 1'b0;
    end

    // Payload only changes on load, so it is stable while waiting for ready
    always_ff @(posedge clk) begin
        if (load_i) pkt_q <= pkt_i;
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;
    assign fire_o  = valid_q && ready_i;

endmodule

// File: rtl/imem_ctrl.sv
// Ifmap memory sequencer: writes the host load stream into the ifmap RAM,
// then per timestep streams FILTER_DIM ifmap rows per output row to the PEs,
// paced by weights-done / row-done packets, and closes each timestep with a
// TSDONE packet.
module imem_ctrl
    import imem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    imem_ctrl_if.slave bus,
    output logic [1:0] cur_ts,
    output logic       busy,
    output logic       all_done,
    output logic [7:0] err_drop
);

    localparam logic [ADDR_W-1:0] PIX_L       = ADDR_W'(IFMAP_DIM * IFMAP_DIM);
    localparam logic [1:0]        NUM_TS_L    = 2'(NUM_TS);
    localparam logic [4:0]        LAST_ROW_L  = 5'(IFMAP_DIM - FILTER_DIM);
    localparam logic [2:0]        LAST_PE_L   = 3'(FILTER_DIM - 1);
    localparam logic [3:0]        PE_BASE_L   = 4'(PE_BASE);
    localparam logic [3:0]        TSDONE_D_L  = 4'(TSDONE_DEST);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [2:0] state_q,    state_d;
    logic [4:0] r_q,        r_d;
    logic [2:0] p_q,        p_d;
    logic [1:0] cur_ts_q,   cur_ts_d;
    logic [7:0] err_q,      err_d;
    logic       all_done_q, all_done_d;
    logic       rd_pend_q,  rd_pend_d;

    logic       drop;
    logic       out_load;
    pkt_t       out_pkt_in;
    logic       out_valid;
    pkt_t       out_pkt;
    logic       out_fire;

    logic [1:0] ts_m1;
    logic [1:0] cur_m1;
    logic       beat_fire;
    logic       beat_ok;
    logic       rin_fire;
    logic [3:0] rin_opc;
    logic       unused_rin_bits;

    assign ts_m1     = bus.load_ts - 2'd1;
    assign cur_m1    = cur_ts_q - 2'd1;
    assign beat_fire = (state_q == ST_LOAD) && bus.load_valid;
    assign beat_ok   = (bus.load_addr < PIX_L) && (bus.load_ts != 2'd0) &&
                       (bus.load_ts <= NUM_TS_L);
    assign rin_fire  = bus.rin_valid && bus.rin_ready;
    assign rin_opc   = bus.rin_pkt[OPC_MSB:OPC_LSB];
    assign unused_rin_bits = ^{bus.rin_pkt[DEST_MSB:DEST_LSB], bus.rin_pkt[PKT_DATA_W-1:0]};

    // Next-state, counters and drop detection for the sequencer
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        p_d        = p_q;
        cur_ts_d   = cur_ts_q;
        all_done_d = 1'b0;
        rd_pend_d  = 1'b0;
        drop       = 1'b0;
        out_load   = 1'b0;
        out_pkt_in = '0;
        case (state_q)
            ST_IDLE: begin
                if (rin_fire)       drop = 1'b1;
                if (bus.load_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (beat_fire && !beat_ok) drop = 1'b1;
                if (bus.load_done) begin
                    state_d  = ST_WAIT_W;
                    cur_ts_d = 2'd1;
                end
            end
            ST_WAIT_W: begin
                if (rin_fire) begin
                    if (rin_opc == OPC_WDONE) begin
                        r_d     = '0;
                        p_d     = '0;
                        state_d = ST_RD_ROW;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_RD_ROW: begin
                rd_pend_d = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                // First SEND cycle is when the RAM row arrives; capture it.
                if (rd_pend_q) begin
                    out_load   = 1'b1;
                    out_pkt_in = make_pkt(PE_BASE_L + {1'b0, p_q}, OPC_IFROW,
                                          PKT_DATA_W'(bus.mem_rdata));
                end else if (out_fire) begin
                    if (p_q < LAST_PE_L) begin
                        p_d     = p_q + 3'd1;
                        state_d = ST_RD_ROW;
                    end else begin
                        state_d = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (rin_fire) begin
                    if (rin_opc == OPC_ROWDONE) begin
                        if (r_q < LAST_ROW_L) begin
                            r_d     = r_q + 5'd1;
                            p_d     = '0;
                            state_d = ST_RD_ROW;
                        end else begin
                            out_load   = 1'b1;
                            out_pkt_in = make_pkt(TSDONE_D_L, OPC_TSDONE,
                                                  PKT_DATA_W'(cur_ts_q));
                            state_d    = ST_TS_END;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_TS_END: begin
                if (out_fire) begin
                    if (cur_ts_q < NUM_TS_L) begin
                        cur_ts_d = cur_ts_q + 2'd1;
                        state_d  = ST_WAIT_W;
                    end else begin
                        all_done_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.load_start) begin
                    cur_ts_d = 2'd0;
                    state_d  = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_d = drop ? sat_inc8(err_q) : err_q;
    end

    // Sequencer state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            p_q        <= '0;
            cur_ts_q   <= '0;
            err_q      <= '0;
            all_done_q <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            p_q        <= p_d;
            cur_ts_q   <= cur_ts_d;
            err_q      <= err_d;
            all_done_q <= all_done_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    imem_ctrl_pkt_out_reg u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (out_load),
        .pkt_i   (out_pkt_in),
        .ready_i (bus.rout_ready),
        .valid_o (out_valid),
        .pkt_o   (out_pkt),
        .fire_o  (out_fire)
    );

    assign bus.load_ready = (state_q == ST_LOAD);
    assign bus.mem_we     = beat_fire && beat_ok;
    assign bus.mem_wts    = ts_m1[0];
    assign bus.mem_waddr  = bus.load_addr;
    assign bus.mem_wdata  = bus.load_data;
    assign bus.mem_re     = (state_q == ST_RD_ROW);
    assign bus.mem_rts    = cur_m1[0];
    assign bus.mem_rrow   = r_q + {2'b00, p_q};
    assign bus.rin_ready  = rst_n && ((state_q == ST_IDLE) || (state_q == ST_WAIT_W) ||
                                      (state_q == ST_WAIT_RD));
    assign bus.rout_valid = out_valid;
    assign bus.rout_pkt   = out_pkt;

    assign cur_ts   = cur_ts_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign all_done = all_done_q;
    assign err_drop = err_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Testbench for imem_ctrl: host load stream, ifmap RAM model and a PE-side
// packet driver, checked against a row-level reference of the image.
module tb_imem_ctrl;
    import imem_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cur_ts;
    logic       busy;
    logic       all_done;
    logic [7:0] err_drop;

    always #5 clk = ~clk;

    imem_ctrl_if bus();

    imem_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cur_ts   (cur_ts),
        .busy     (busy),
        .all_done (all_done),
        .err_drop (err_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int tmo      = 0;
    int rr_mode  = 1;   // 0: never ready, 1: always ready, 2: random stalls

    logic [24:0] img [2][25];   // intended image: bank, row -> row bits
    logic [24:0] ram [2][25];   // external RAM contents

    logic [13:0] we_log[$];
    logic [13:0] exp_we[$];
    logic [32:0] out_log[$];
    int          all_done_cnt = 0;
    int          stab_err     = 0;
    logic        prev_hold    = 1'b0;
    logic [32:0] prev_pkt;

    // External ifmap RAM: bit writes, one-cycle row reads
    always @(posedge clk) begin
        if (bus.mem_we)
            ram[bus.mem_wts][int'(bus.mem_waddr) / 25][int'(bus.mem_waddr) % 25] <= bus.mem_wdata;
        if (bus.mem_re)
            bus.mem_rdata <= ram[bus.mem_rts][bus.mem_rrow];
    end

    // Recorder for writes, accepted outbound packets, all_done and hold stability
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold <= 1'b0;
        end else begin
            if (bus.mem_we) we_log.push_back({bus.mem_wts, bus.mem_waddr, bus.mem_wdata});
            if (all_done) all_done_cnt <= all_done_cnt + 1;
            if (prev_hold && (!bus.rout_valid || bus.rout_pkt !== prev_pkt))
                stab_err <= stab_err + 1;
            if (bus.rout_valid && bus.rout_ready) out_log.push_back(bus.rout_pkt);
            prev_hold <= bus.rout_valid && !bus.rout_ready;
            prev_pkt  <= bus.rout_pkt;
        end
    end

    // Router back-pressure generator
    initial begin
        bus.rout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       bus.rout_ready = 1'b0;
                1:       bus.rout_ready = 1'b1;
                default: bus.rout_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [32:0] mk(input int dest, input int opc, input logic [24:0] d);
        return {4'(dest), 4'(opc), d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_ts    = 2'd0;
        bus.load_addr  = '0;
        bus.load_data  = 1'b0;
        bus.load_done  = 1'b0;
        bus.rin_valid  = 1'b0;
        bus.rin_pkt    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        we_log.delete();
        out_log.delete();
        all_done_cnt = 0;
        stab_err     = 0;
    endtask

    task automatic send_rin(input logic [32:0] pkt);
        bit ok;
        ok = 1'b0;
        bus.rin_pkt   = pkt;
        bus.rin_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rin_ready;
            tick();
        end
        bus.rin_valid = 1'b0;
        if (!ok) tmo++;
    endtask

    task automatic wait_out(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            if (out_log.size() >= n) ok = 1'b1;
            else tick();
        end
        if (!ok) tmo++;
    endtask

    task automatic random_img();
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 25; r++) img[t][r] = 25'($urandom);
    endtask

    // Streams both banks of img; the final beat shares its cycle with load_done
    task automatic load_all();
        exp_we.delete();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            for (int a = 0; a < 625; a++) begin
                bus.load_valid = 1'b0;
                while ($urandom_range(0, 3) == 0) tick();
                bus.load_valid = 1'b1;
                bus.load_ts    = 2'(t + 1);
                bus.load_addr  = 12'(a);
                bus.load_data  = img[t][a / 25][a % 25];
                exp_we.push_back({1'(t), 12'(a), img[t][a / 25][a % 25]});
                if (t == 1 && a == 624) bus.load_done = 1'b1;
                tick();
            end
        end
        bus.load_valid = 1'b0;
        bus.load_done  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (bus.rout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rout_valid got=%b exp=0", bus.rout_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (cur_ts !== 2'd0) begin n_fail++; $display("FAIL reset_cur_ts got=%0d exp=0", cur_ts); end
        n_checks++; if (err_drop !== 8'd0) begin n_fail++; $display("FAIL reset_err_drop got=%0d exp=0", err_drop); end
        n_checks++; if ({bus.load_ready, bus.mem_we, bus.mem_re, all_done} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes got=%b exp=0000", {bus.load_ready, bus.mem_we, bus.mem_re, all_done}); end
        tick();
        send_rin(mk(5, 1, 25'h1));
        @(negedge clk);
        n_checks++; if (err_drop !== 8'd1) begin n_fail++; $display("FAIL idle_drop err_drop got=%0d exp=1", err_drop); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_drop busy got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_load();
        int bad;
        int t0;
        t0 = tmo;
        do_reset();
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 25; r++)
                for (int c = 0; c < 25; c++) begin
                    int a;
                    a = r * 25 + c;
                    img[t][r][c] = a[0];
                end
        load_all();
        @(negedge clk);
        n_checks++; if (we_log.size() !== 1250) begin n_fail++; $display("FAIL load_we_count got=%0d exp=1250", we_log.size()); end
        bad = 0;
        for (int i = 0; i < exp_we.size() && i < we_log.size(); i++)
            if (we_log[i] !== exp_we[i]) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL load_we_content mismatched_beats got=%0d exp=0", bad); end
        n_checks++; if (err_drop !== 8'd0) begin n_fail++; $display("FAIL load_err_drop got=%0d exp=0", err_drop); end
        n_checks++; if (cur_ts !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL load_to_wait cur_ts=%0d busy=%b exp 1/1", cur_ts, busy); end
        n_checks++; if (tmo != t0) begin n_fail++; $display("FAIL load_timeouts got=%0d exp=0", tmo - t0); end
        tick();
    endtask

    task automatic test_bad_beats();
        do_reset();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_ts    = 2'd1;
        bus.load_addr  = 12'd625;
        bus.load_data  = 1'b1;
        tick();
        bus.load_ts    = 2'd3;
        bus.load_addr  = 12'd0;
        tick();
        bus.load_valid = 1'b0;
        bus.load_done  = 1'b1;
        tick();
        bus.load_done  = 1'b0;
        @(negedge clk);
        n_checks++; if (we_log.size() !== 0) begin n_fail++; $display("FAIL bad_beats_we got=%0d exp=0", we_log.size()); end
        n_checks++; if (err_drop !== 8'd2) begin n_fail++; $display("FAIL bad_beats_err got=%0d exp=2", err_drop); end
        n_checks++; if (cur_ts !== 2'd1) begin n_fail++; $display("FAIL bad_beats_cur_ts got=%0d exp=1", cur_ts); end
        tick();
    endtask

    task automatic test_first_rows();
        int t0;
        t0 = tmo;
        do_reset();
        random_img();
        for (int k = 0; k < 25; k++) img[0][k] = 25'(k);
        load_all();
        rr_mode = 1;
        send_rin(mk(SELF_ADDR, 0, 25'h0));
        wait_out(5);
        send_rin(mk(SELF_ADDR, 2, 25'h0));
        wait_out(10);
        for (int i = 0; i < 10; i++) begin
            logic [32:0] e;
            e = mk(5 + i % 5, 1, 25'(i / 5 + i % 5));
            n_checks++;
            if (i >= out_log.size() || out_log[i] !== e) begin
                n_fail++;
                $display("FAIL first_rows pkt%0d got=%h exp=%h", i, (i < out_log.size()) ? out_log[i] : 33'h0, e);
            end
        end
        n_checks++; if (tmo != t0) begin n_fail++; $display("FAIL first_rows_timeouts got=%0d exp=0", tmo - t0); end
    endtask

    task automatic test_reset_mid_send();
        bit seen;
        do_reset();
        random_img();
        load_all();
        rr_mode = 0;
        send_rin(mk(SELF_ADDR, 7, 25'h0));
        send_rin(mk(SELF_ADDR, 0, 25'h0));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rout_valid;
            if (!seen) tick();
        end
        n_checks++; if (!seen || err_drop !== 8'd1) begin n_fail++; $display("FAIL mid_send_setup valid=%b err_drop=%0d exp 1/1", seen, err_drop); end
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if (bus.rout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_send_rout_valid got=%b exp=0", bus.rout_valid); end
        n_checks++; if (busy !== 1'b0 || cur_ts !== 2'd0) begin n_fail++; $display("FAIL mid_send_state busy=%b cur_ts=%0d exp 0/0", busy, cur_ts); end
        n_checks++; if (err_drop !== 8'd0) begin n_fail++; $display("FAIL mid_send_err got=%0d exp=0", err_drop); end
        tick();
        rst_n   = 1'b1;
        rr_mode = 1;
    endtask

    task automatic test_drop_inject();
        int t0;
        t0 = tmo;
        do_reset();
        random_img();
        load_all();
        rr_mode = 2;
        send_rin(mk(SELF_ADDR, 7, 25'h5));
        send_rin(mk(SELF_ADDR, 0, 25'h0));
        wait_out(5);
        send_rin(mk(SELF_ADDR, 7, 25'h0));
        send_rin(mk(SELF_ADDR, 2, 25'h0));
        wait_out(10);
        for (int i = 0; i < 10; i++) begin
            logic [32:0] e;
            e = mk(5 + i % 5, 1, img[0][i / 5 + i % 5]);
            n_checks++;
            if (i >= out_log.size() || out_log[i] !== e) begin
                n_fail++;
                $display("FAIL drop_inject pkt%0d got=%h exp=%h", i, (i < out_log.size()) ? out_log[i] : 33'h0, e);
            end
        end
        @(negedge clk);
        n_checks++; if (err_drop !== 8'd2) begin n_fail++; $display("FAIL drop_inject_err got=%0d exp=2", err_drop); end
        n_checks++; if (tmo != t0) begin n_fail++; $display("FAIL drop_inject_timeouts got=%0d exp=0", tmo - t0); end
        tick();
    endtask

    task automatic test_full_run();
        logic [32:0] exp_q[$];
        int bad;
        int nrow;
        int t0;
        t0 = tmo;
        do_reset();
        random_img();
        load_all();
        rr_mode = 2;
        for (int t = 0; t < 2; t++) begin
            send_rin(mk(SELF_ADDR, 0, 25'h0));
            for (int r = 0; r < 21; r++) begin
                wait_out(t * 106 + 5 * (r + 1));
                send_rin(mk(SELF_ADDR, 2, 25'h0));
            end
            wait_out(t * 106 + 106);
        end
        tick();
        tick();
        for (int t = 0; t < 2; t++) begin
            for (int r = 0; r < 21; r++)
                for (int p = 0; p < 5; p++) exp_q.push_back(mk(5 + p, 1, img[t][r + p]));
            exp_q.push_back(mk(12, 10, 25'(t + 1)));
        end
        n_checks++; if (out_log.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_pkt_count got=%0d exp=%0d", out_log.size(), exp_q.size()); end
        bad  = 0;
        nrow = 0;
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            if (out_log[i] !== exp_q[i]) bad++;
            if (out_log[i][28:25] == 4'd1) nrow++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_pkt_content mismatched=%0d exp=0", bad); end
        n_checks++; if (nrow != 210) begin n_fail++; $display("FAIL full_ifrow_count got=%0d exp=210", nrow); end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL full_hold_stability violations=%0d exp=0", stab_err); end
        n_checks++; if (all_done_cnt != 1) begin n_fail++; $display("FAIL full_all_done_pulses got=%0d exp=1", all_done_cnt); end
        n_checks++; if (tmo != t0) begin n_fail++; $display("FAIL full_timeouts got=%0d exp=0", tmo - t0); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || cur_ts !== 2'd2 || err_drop !== 8'd0) begin n_fail++; $display("FAIL full_done_state busy=%b cur_ts=%0d err=%0d exp 0/2/0", busy, cur_ts, err_drop); end
        tick();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.load_ready !== 1'b1 || cur_ts !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL done_reload ready=%b cur_ts=%0d busy=%b exp 1/0/1", bus.load_ready, cur_ts, busy); end
        tick();
    endtask

    task automatic test_err_saturate();
        int t0;
        t0 = tmo;
        do_reset();
        for (int i = 0; i < 260; i++) send_rin(mk(0, 3, 25'(i)));
        @(negedge clk);
        n_checks++; if (err_drop !== 8'd255) begin n_fail++; $display("FAIL err_saturate got=%0d exp=255", err_drop); end
        n_checks++; if (tmo != t0) begin n_fail++; $display("FAIL err_saturate_timeouts got=%0d exp=0", tmo - t0); end
        tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_ts    = 2'd0;
        bus.load_addr  = '0;
        bus.load_data  = 1'b0;
        bus.load_done  = 1'b0;
        bus.rin_valid  = 1'b0;
        bus.rin_pkt    = '0;
        test_reset();
        test_load();
        test_bad_beats();
        test_first_rows();
        test_reset_mid_send();
        test_drop_inject();
        test_full_run();
        test_err_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
